// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// Holds the RISC-V opcode/func3/func7 encodings, the ALU operation codes driven
// on alu_control, the datapath mux encodings, the sequencer state enum and the
// NOP instruction loaded into the IR at reset.
package control_sequencer_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_STD = 7'h00;
    localparam logic [6:0] F7_ALT = 7'h20;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_SADD = 2'b11;

    localparam logic [1:0] SA_PC   = 2'b00;
    localparam logic [1:0] SA_ZERO = 2'b01;
    localparam logic [1:0] SA_RS1  = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// ctrl_decode: purely combinational decode of the latched instruction.
// Inputs : opcode/func3/func7 fields of the IR, alu_zero/alu_last_bit for branches.
// Outputs: datapath mux/ALU controls, branch/jump target select, and the
//          classification flags the sequencer FSM steps on.
module ctrl_decode
    import control_sequencer_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       alu_zero,
    input  logic       alu_last_bit,
    output logic [3:0] alu_control,
    output logic [2:0] imm_source,
    output logic       alu_source,
    output logic [1:0] write_back_source,
    output logic [1:0] second_add_source,
    output logic       pc_source,
    output logic       writes_rd,
    output logic       is_load,
    output logic       is_store,
    output logic       is_illegal,
    output logic       is_shift_bad
);

    logic shift_f7_ok;
    assign shift_f7_ok = (func7 == F7_STD) || (func7 == F7_ALT);

    always_comb begin
        alu_control       = ALU_ADD;
        imm_source        = IMM_I;
        alu_source        = 1'b0;
        write_back_source = WB_ALU;
        second_add_source = SA_PC;
        pc_source         = 1'b0;
        writes_rd         = 1'b0;
        is_load           = 1'b0;
        is_store          = 1'b0;
        is_illegal        = 1'b0;
        is_shift_bad      = 1'b0;

        case (opcode)
            OPC_R, OPC_I_ALU: begin
                writes_rd  = 1'b1;
                alu_source = (opcode == OPC_I_ALU);
                case (func3)
                    F3_ADD_SUB: alu_control = (opcode == OPC_R && func7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    F3_SLL: begin
                        alu_control  = ALU_SLL;
                        // slli encodes shamt in [24:20]; upper bits must be zero
                        is_shift_bad = (opcode == OPC_I_ALU) && (func7 != F7_STD);
                    end
                    F3_SLT:     alu_control = ALU_SLT;
                    F3_SLTU:    alu_control = ALU_SLTU;
                    F3_XOR:     alu_control = ALU_XOR;
                    F3_SRL_SRA: begin
                        alu_control  = (func7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        is_shift_bad = !shift_f7_ok;
                    end
                    F3_OR:      alu_control = ALU_OR;
                    default:    alu_control = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                is_load           = 1'b1;
                alu_source        = 1'b1;
                write_back_source = WB_MEM;
            end
            OPC_STORE: begin
                is_store   = 1'b1;
                alu_source = 1'b1;
                imm_source = IMM_S;
            end
            OPC_BRANCH: begin
                imm_source = IMM_B;
                case (func3)
                    F3_BEQ:  begin alu_control = ALU_SUB;  pc_source = alu_zero;      end
                    F3_BNE:  begin alu_control = ALU_SUB;  pc_source = !alu_zero;     end
                    F3_BLT:  begin alu_control = ALU_SLT;  pc_source = alu_last_bit;  end
                    F3_BGE:  begin alu_control = ALU_SLT;  pc_source = !alu_last_bit; end
                    F3_BLTU: begin alu_control = ALU_SLTU; pc_source = alu_last_bit;  end
                    F3_BGEU: begin alu_control = ALU_SLTU; pc_source = !alu_last_bit; end
                    default: pc_source = 1'b0;
                endcase
            end
            OPC_JAL: begin
                writes_rd         = 1'b1;
                imm_source        = IMM_J;
                write_back_source = WB_PC4;
                pc_source         = 1'b1;
            end
            OPC_JALR: begin
                writes_rd         = 1'b1;
                alu_source        = 1'b1;
                write_back_source = WB_PC4;
                second_add_source = SA_RS1;
                pc_source         = 1'b1;
            end
            OPC_LUI: begin
                writes_rd         = 1'b1;
                imm_source        = IMM_U;
                write_back_source = WB_SADD;
                second_add_source = SA_ZERO;
            end
            OPC_AUIPC: begin
                writes_rd         = 1'b1;
                imm_source        = IMM_U;
                write_back_source = WB_SADD;
                second_add_source = SA_PC;
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/EXEC/MEM/WB control unit with
// handshaked instruction and data ports, sticky illegal/bus-timeout traps.
//
// state | meaning
// FETCH | instr_ready high, latch instr into IR on instr_valid
// EXEC  | decode IR; retire ALU/branch/jump or enter MEM for load/store
// MEM   | d_req high until d_ready; timeout counter runs
// WB    | load data written back, retire
// HALT  | trapped; only reset leaves
//
// Ports: clk/rst (async active-high), instr/instr_valid/instr_ready fetch port,
// d_req/d_we/d_ready data port, alu_zero/alu_last_bit branch flags, decoded
// datapath controls, reg_write/pc_write strobes, sticky illegal/bus_error, state_o.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 256,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        alu_zero,
    input  logic        alu_last_bit,
    output logic        d_req,
    output logic        d_we,
    input  logic        d_ready,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_source,
    output logic        alu_source,
    output logic [1:0]  write_back_source,
    output logic [1:0]  second_add_source,
    output logic        reg_write,
    output logic        pc_write,
    output logic        pc_source,
    output logic        illegal,
    output logic        bus_error,
    output logic [2:0]  state_o
);

    // A zero timeout still needs a 1-bit counter to keep the datapath legal.
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    seq_state_t       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_error_q, bus_error_d;

    logic [1:0] dec_wbs;
    logic       dec_pc_src, dec_writes_rd, dec_load, dec_store, dec_illegal, dec_shift_bad;

    logic ir_fields_unused;
    assign ir_fields_unused = ^{ir_q[24:15], ir_q[11:7]};

    ctrl_decode u_decode (
        .opcode            (ir_q[6:0]),
        .func3             (ir_q[14:12]),
        .func7             (ir_q[31:25]),
        .alu_zero          (alu_zero),
        .alu_last_bit      (alu_last_bit),
        .alu_control       (alu_control),
        .imm_source        (imm_source),
        .alu_source        (alu_source),
        .write_back_source (dec_wbs),
        .second_add_source (second_add_source),
        .pc_source         (dec_pc_src),
        .writes_rd         (dec_writes_rd),
        .is_load           (dec_load),
        .is_store          (dec_store),
        .is_illegal        (dec_illegal),
        .is_shift_bad      (dec_shift_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            ir_q        <= NOP_INSTR;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        ir_d              = ir_q;
        cnt_d             = cnt_q;
        illegal_d         = illegal_q;
        bus_error_d       = bus_error_q;
        instr_ready       = 1'b0;
        d_req             = 1'b0;
        d_we              = 1'b0;
        reg_write         = 1'b0;
        pc_write          = 1'b0;
        pc_source         = dec_pc_src;
        write_back_source = dec_wbs;

        case (state_q)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (dec_illegal) begin
                    if (TRAP_ILLEGAL != 0) begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end else begin
                        pc_write  = 1'b1;
                        pc_source = 1'b0;
                        state_d   = FETCH;
                    end
                end else if (dec_load || dec_store) begin
                    cnt_d   = '0;
                    state_d = MEM;
                end else begin
                    // malformed shift encodings retire as a NOP
                    pc_write  = 1'b1;
                    reg_write = dec_writes_rd && !dec_shift_bad;
                    if (dec_shift_bad) pc_source = 1'b0;
                    state_d   = FETCH;
                end
            end
            MEM: begin
                d_req = 1'b1;
                d_we  = dec_store;
                if (d_ready) begin
                    if (dec_store) begin
                        pc_write  = 1'b1;
                        pc_source = 1'b0;
                        state_d   = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (MEM_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = HALT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                write_back_source = WB_MEM;
                reg_write         = 1'b1;
                pc_write          = 1'b1;
                pc_source         = 1'b0;
                state_d           = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_zero;
    logic        alu_last_bit;
    logic        d_req;
    logic        d_we;
    logic        d_ready;
    logic [3:0]  alu_control;
    logic [2:0]  imm_source;
    logic        alu_source;
    logic [1:0]  write_back_source;
    logic [1:0]  second_add_source;
    logic        reg_write;
    logic        pc_write;
    logic        pc_source;
    logic        illegal;
    logic        bus_error;
    logic [2:0]  state_o;

    int n_chk = 0;
    int n_err = 0;

    control_sequencer #(.MEM_TIMEOUT(4), .TRAP_ILLEGAL(1)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr             (instr),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .alu_zero          (alu_zero),
        .alu_last_bit      (alu_last_bit),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_ready           (d_ready),
        .alu_control       (alu_control),
        .imm_source        (imm_source),
        .alu_source        (alu_source),
        .write_back_source (write_back_source),
        .second_add_source (second_add_source),
        .reg_write         (reg_write),
        .pc_write          (pc_write),
        .pc_source         (pc_source),
        .illegal           (illegal),
        .bus_error         (bus_error),
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; instr_valid = 1'b0;
        alu_zero = 1'b0; alu_last_bit = 1'b0; d_ready = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state_o), 32'(FETCH));
        chk("rst_d_req", 32'(d_req), 0);
        chk("rst_reg_write", 32'(reg_write), 0);
        chk("rst_pc_write", 32'(pc_write), 0);
        chk("rst_instr_ready", 32'(instr_ready), 1);
        chk("rst_flags", 32'({illegal, bus_error}), 0);
        chk("rst_nop_alu", 32'(alu_control), 32'(ALU_ADD));
        chk("rst_nop_alusrc", 32'(alu_source), 1);
        rst = 1'b0;

        // addi x1,x0,5 with valid held
        instr = 32'h0050_0093; instr_valid = 1'b1; #1;
        chk("addi_fetch_strobes", 32'({reg_write, pc_write}), 0);
        tick();
        chk("addi_exec_state", 32'(state_o), 32'(EXEC));
        chk("addi_exec_strobes", 32'({reg_write, pc_write}), 32'b11);
        chk("addi_alu", 32'(alu_control), 32'(ALU_ADD));
        chk("addi_alusrc", 32'(alu_source), 1);
        chk("addi_exec_ready", 32'(instr_ready), 0);

        // lw x2,0(x1), d_ready on third MEM cycle
        instr = 32'h0000_A103;
        tick();
        chk("addi_back_fetch", 32'(state_o), 32'(FETCH));
        chk("fetch_no_strobe", 32'({reg_write, pc_write}), 0);
        tick();
        instr_valid = 1'b0; #1;
        chk("lw_exec_strobes", 32'({reg_write, pc_write}), 0);
        tick();
        chk("lw_mem1_req", 32'({d_req, d_we}), 32'b10);
        chk("lw_mem1_strobes", 32'({reg_write, pc_write}), 0);
        tick();
        chk("lw_mem2_req", 32'(d_req), 1);
        tick();
        d_ready = 1'b1; #1;
        chk("lw_mem3_req", 32'({d_req, d_we}), 32'b10);
        chk("lw_mem3_pc_write", 32'(pc_write), 0);
        tick();
        d_ready = 1'b0; #1;
        chk("lw_wb_state", 32'(state_o), 32'(WB));
        chk("lw_wb_d_req", 32'(d_req), 0);
        chk("lw_wb_strobes", 32'({reg_write, pc_write}), 32'b11);
        chk("lw_wb_wbs", 32'(write_back_source), 32'b01);
        tick();
        chk("lw_done_fetch", 32'(state_o), 32'(FETCH));
        chk("lw_done_pc_write", 32'(pc_write), 0);

        // sw x2,4(x1), d_ready in first MEM cycle
        instr = 32'h0020_A223; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; #1;
        chk("sw_imm", 32'(imm_source), 32'b001);
        chk("sw_exec_pc_write", 32'(pc_write), 0);
        tick();
        d_ready = 1'b1; #1;
        chk("sw_mem_req", 32'({d_req, d_we}), 32'b11);
        chk("sw_mem_strobes", 32'({reg_write, pc_write, pc_source}), 32'b010);
        tick();
        d_ready = 1'b0; #1;
        chk("sw_done_fetch", 32'(state_o), 32'(FETCH));

        // beq x0,x0,8 taken then not taken
        instr = 32'h0000_0463; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; alu_zero = 1'b1; #1;
        chk("beq_taken", 32'({reg_write, pc_write, pc_source}), 32'b011);
        chk("beq_alu", 32'(alu_control), 32'(ALU_SUB));
        tick();
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; alu_zero = 1'b0; #1;
        chk("beq_not_taken", 32'({reg_write, pc_write, pc_source}), 32'b010);
        tick();

        // slli with func7=0x20 retires as NOP
        instr = 32'h4010_1093; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; #1;
        chk("slli_bad", 32'({reg_write, pc_write}), 32'b01);
        tick();

        // srai x1,x0,1 is legal
        instr = 32'h4010_5093; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; #1;
        chk("srai_strobes", 32'({reg_write, pc_write}), 32'b11);
        chk("srai_alu", 32'(alu_control), 32'(ALU_SRA));
        tick();

        // store with no d_ready: 4 MEM cycles then bus_error
        instr = 32'h0020_A223; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("to_mem1", 32'(state_o), 32'(MEM));
        tick(); tick(); tick();
        chk("to_mem4_still_req", 32'({d_req, bus_error}), 32'b10);
        tick();
        chk("to_halt_state", 32'(state_o), 32'(HALT));
        chk("to_bus_error", 32'(bus_error), 1);
        chk("to_d_req_drop", 32'(d_req), 0);
        rst = 1'b1; #1;
        chk("to_rst_clear", 32'({bus_error, state_o}), 32'(FETCH));
        tick();
        rst = 1'b0;

        // reset mid-MEM
        instr = 32'h0000_A103; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("midmem_req", 32'(d_req), 1);
        rst = 1'b1; #1;
        chk("midmem_rst_req", 32'(d_req), 0);
        chk("midmem_rst_state", 32'(state_o), 32'(FETCH));
        tick();
        rst = 1'b0;

        // illegal opcode traps
        instr = 32'h0000_0000; instr_valid = 1'b1;
        tick();
        chk("ill_exec_strobes", 32'({reg_write, pc_write}), 0);
        tick();
        chk("ill_halt", 32'({illegal, instr_ready}), 32'b10);
        tick(); tick(); tick();
        chk("ill_stays_halt", 32'(state_o), 32'(HALT));
        chk("ill_halt_quiet", 32'({instr_ready, d_req, reg_write, pc_write}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
